// File: rtl/msu_audio_sample_out.sv
// msu_audio_sample_out: PCM sink for the MSU-1 sector stream.
// Drops header and loop-skip words, queues stereo words in a FIFO, reports the
// fill level for flow control and emits one L/R pair per output sample tick.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a sample tick
// S_RD_L  | reading the left word from the FIFO RAM
// S_RD_R  | reading the right word, left word captured into hold
// S_LATCH | new pair presented on audio_l/audio_r, strobe high
module msu_audio_sample_out #(
    parameter int unsigned CLK_HZ     = 21477272,
    parameter int unsigned SAMPLE_HZ  = 44100,
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trackmounting,
    input  logic                  trig_play,
    input  logic                  audio_play,
    input  logic                  sd_ack_1,
    input  logic                  sd_buff_wr,
    input  logic [15:0]           sd_buff_dout,
    input  logic [20:0]           sd_lba_1,
    input  logic                  ignore_sd_buffer_out,
    output logic [DEPTH_LOG2:0]   audio_fifo_usedw,
    output logic [15:0]           audio_l,
    output logic [15:0]           audio_r,
    output logic                  sample_strobe,
    output logic [15:0]           underrun_count,
    output logic                  overflow
);

    localparam int unsigned        DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PAIR_LVL = (DEPTH_LOG2 + 1)'(2);

    typedef enum logic [1:0] {S_IDLE, S_RD_L, S_RD_R, S_LATCH} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            mem [DEPTH];
    logic [15:0]            rd_data_q;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    usedw_q, usedw_d;
    logic [8:0]             idx_q, idx_d, idx_cur;
    logic [31:0]            acc_q, acc_sum;
    logic [15:0]            underrun_q, audio_l_q, audio_r_q, l_hold_q;
    logic                   ack_q, phase_q, overflow_q, zero_strobe_q;
    logic                   flush, accept, full, wr_en, rd_en, latch;
    logic                   tick, can_pop, zero_tick;

    assign flush     = reset | trackmounting | trig_play;
    assign idx_cur   = (sd_ack_1 && !ack_q) ? 9'd0 : idx_q;
    // Words 0..3 of sector 0 carry the "MSU1" tag and loop offset, never audio.
    assign accept    = sd_ack_1 && sd_buff_wr && !ignore_sd_buffer_out
                       && !((sd_lba_1 == 21'd0) && (idx_cur < 9'd4));
    assign full      = (usedw_q == FULL_LVL);
    assign wr_en     = accept && !full && !flush;
    assign acc_sum   = acc_q + SAMPLE_HZ;
    assign tick      = !reset && (acc_sum >= CLK_HZ);
    assign can_pop   = audio_play && (usedw_q >= PAIR_LVL);
    assign zero_tick = tick && (state_q == S_IDLE) && !can_pop && !flush;

    assign audio_fifo_usedw = usedw_q;
    assign underrun_count   = underrun_q;
    assign overflow         = overflow_q;

    // Pointer, fill-level and sector word index next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_en);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd_en);
        usedw_d  = usedw_q;
        case ({wr_en, rd_en})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase
        idx_d = idx_cur;
        if (sd_ack_1 && sd_buff_wr && (idx_cur != 9'h1FF))
            idx_d = idx_cur + 9'd1;
    end

    // Pop FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Pop FSM next state; a flush abandons any pair in flight.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (tick && can_pop) state_d = S_RD_L;
                S_RD_L:  state_d = S_RD_R;
                S_RD_R:  state_d = S_LATCH;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pop FSM outputs; the fresh pair is shown during LATCH and held afterwards.
    always_comb begin
        rd_en         = !flush && ((state_q == S_RD_L) || (state_q == S_RD_R));
        latch         = !flush && (state_q == S_LATCH);
        sample_strobe = latch || zero_strobe_q;
        audio_l       = latch ? l_hold_q  : audio_l_q;
        audio_r       = latch ? rd_data_q : audio_r_q;
    end

    // FIFO RAM with registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= sd_buff_dout;
        if (rd_en) rd_data_q     <= mem[rd_ptr_q];
    end

    // Tick accumulator, sector word index and underrun counter (cleared only by reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            ack_q      <= 1'b0;
            idx_q      <= '0;
            underrun_q <= '0;
        end else begin
            acc_q <= tick ? (acc_sum - CLK_HZ) : acc_sum;
            ack_q <= sd_ack_1;
            idx_q <= idx_d;
            if (zero_tick && audio_play && (underrun_q != 16'hFFFF))
                underrun_q <= underrun_q + 16'd1;
        end
    end

    // FIFO control and output holding registers; flush takes priority over all traffic.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            usedw_q       <= '0;
            phase_q       <= 1'b0;
            overflow_q    <= 1'b0;
            audio_l_q     <= '0;
            audio_r_q     <= '0;
            l_hold_q      <= '0;
            zero_strobe_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            usedw_q       <= usedw_d;
            phase_q       <= phase_q ^ wr_en;
            overflow_q    <= overflow_q | (accept && full);
            zero_strobe_q <= zero_tick;
            if (state_q == S_RD_R) l_hold_q <= rd_data_q;
            if (zero_tick) begin
                audio_l_q <= '0;
                audio_r_q <= '0;
            end else if (latch) begin
                audio_l_q <= l_hold_q;
                audio_r_q <= rd_data_q;
            end
        end
    end

endmodule

// File: tb/tb_msu_audio_sample_out.sv
// Scoreboard bench for msu_audio_sample_out: accepted words are queued on drive,
// each sample tick turns them into an expected L/R pair (or a silent pair), and
// every strobe pops and compares one pair.
module tb_msu_audio_sample_out;

    localparam int unsigned CLK_HZ    = 21477272;
    localparam int unsigned SAMPLE_HZ = 44100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trackmounting = 1'b0;
    logic        trig_play = 1'b0;
    logic        audio_play = 1'b0;
    logic        sd_ack_1 = 1'b0;
    logic        sd_buff_wr = 1'b0;
    logic [15:0] sd_buff_dout = 16'h0;
    logic [20:0] sd_lba_1 = 21'h0;
    logic        ignore_sd_buffer_out = 1'b0;
    logic [11:0] audio_fifo_usedw;
    logic [15:0] audio_l, audio_r, underrun_count;
    logic        sample_strobe, overflow;

    always #5 clk = ~clk;

    msu_audio_sample_out #(
        .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .DEPTH_LOG2(11)
    ) dut (
        .clk(clk), .reset(reset), .trackmounting(trackmounting),
        .trig_play(trig_play), .audio_play(audio_play), .sd_ack_1(sd_ack_1),
        .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout), .sd_lba_1(sd_lba_1),
        .ignore_sd_buffer_out(ignore_sd_buffer_out),
        .audio_fifo_usedw(audio_fifo_usedw), .audio_l(audio_l), .audio_r(audio_r),
        .sample_strobe(sample_strobe), .underrun_count(underrun_count),
        .overflow(overflow)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [31:0] pair_q[$];
    logic [31:0] m_acc = 32'd0;
    logic [15:0] m_underrun = 16'd0;
    logic        m_overflow = 1'b0;
    logic        m_tick;

    assign m_tick = !reset && ((m_acc + SAMPLE_HZ) >= CLK_HZ);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: accumulator, flush handling and per-tick expected pair.
    always @(posedge clk) begin
        logic        tk;
        logic [15:0] l, r;
        tk = !reset && ((m_acc + SAMPLE_HZ) >= CLK_HZ);
        if (reset || trackmounting || trig_play) begin
            exp_q.delete();
            pair_q.delete();
            m_overflow = 1'b0;
            if (reset) m_underrun = 16'd0;
        end else if (tk) begin
            if (audio_play && exp_q.size() >= 2) begin
                l = exp_q.pop_front();
                r = exp_q.pop_front();
                pair_q.push_back({l, r});
            end else begin
                pair_q.push_back(32'h0);
                if (audio_play && m_underrun != 16'hFFFF) m_underrun = m_underrun + 16'd1;
            end
        end
        if (reset)   m_acc = 32'd0;
        else if (tk) m_acc = m_acc + SAMPLE_HZ - CLK_HZ;
        else         m_acc = m_acc + SAMPLE_HZ;
    end

    // Every strobe consumes one expected pair.
    always @(negedge clk) begin
        logic [31:0] p;
        if (reset === 1'b0 && sample_strobe === 1'b1) begin
            if (pair_q.size() == 0) begin
                check("unexpected_strobe", 32'(sample_strobe), 32'd0);
            end else begin
                p = pair_q.pop_front();
                check("sb_audio_l", 32'(audio_l), 32'(p[31:16]));
                check("sb_audio_r", 32'(audio_r), 32'(p[15:0]));
            end
        end
    end

    task automatic model_write(input logic [20:0] lba, input int idx, input logic ign,
                               input logic [15:0] d);
        if (!ign && !(lba == 21'd0 && idx < 4)) begin
            if (exp_q.size() == 2048) m_overflow = 1'b1;
            else                      exp_q.push_back(d);
        end
    endtask

    task automatic send_sector(input logic [20:0] lba, input int n, input logic [15:0] base,
                               input int n_ign);
        @(negedge clk);
        sd_lba_1   = lba;
        sd_ack_1   = 1'b1;
        sd_buff_wr = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sd_buff_wr           = 1'b1;
            sd_buff_dout         = 16'(base + 16'(i));
            ignore_sd_buffer_out = (i < n_ign);
            model_write(lba, i, ignore_sd_buffer_out, sd_buff_dout);
        end
        @(negedge clk);
        sd_buff_wr           = 1'b0;
        ignore_sd_buffer_out = 1'b0;
        sd_ack_1             = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (sample_strobe !== 1'b1 && cyc < max_cyc);
        if (sample_strobe !== 1'b1) check({tag, "_timeout"}, 32'(sample_strobe), 32'd1);
    endtask

    task automatic pulse_trig_play();
        @(negedge clk);
        trig_play = 1'b1;
        @(negedge clk);
        trig_play = 1'b0;
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        // Reset state and first tick timing
        repeat (3) @(negedge clk);
        check("rst_usedw", 32'(audio_fifo_usedw), 32'd0);
        check("rst_audio_l", 32'(audio_l), 32'd0);
        check("rst_audio_r", 32'(audio_r), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("rst_underrun", 32'(underrun_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        wait_strobe("first_strobe", 600, c);
        check("first_strobe_cycle", 32'((c == 487) || (c == 488)), 32'd1);

        // Sector 0: header words dropped
        send_sector(21'd0, 256, 16'h0000, 0);
        check("t2_usedw", 32'(audio_fifo_usedw), 32'd252);
        check("t2_usedw_model", 32'(audio_fifo_usedw), 32'(exp_q.size()));
        wait_strobe("t2_sync", 600, c);
        audio_play = 1'b1;
        wait_strobe("t2_pop", 600, c);
        check("t2_first_l", 32'(audio_l), 32'h0004);
        check("t2_first_r", 32'(audio_r), 32'h0005);
        check("t2_usedw_after", 32'(audio_fifo_usedw), 32'd250);
        audio_play = 1'b0;
        pulse_trig_play();
        check("t2_flush_usedw", 32'(audio_fifo_usedw), 32'd0);

        // Loop-offset skip on a non-header sector
        send_sector(21'd5, 256, 16'h0000, 10);
        check("t3_usedw", 32'(audio_fifo_usedw), 32'd246);
        wait_strobe("t3_sync", 600, c);
        audio_play = 1'b1;
        wait_strobe("t3_pop", 600, c);
        check("t3_first_l", 32'(audio_l), 32'h000A);
        check("t3_first_r", 32'(audio_r), 32'h000B);
        audio_play = 1'b0;
        pulse_trig_play();

        // Fill to capacity, then overflow
        for (int s = 0; s < 8; s++) send_sector(21'd7, 256, 16'(16'h1000 + 16'(s * 256)), 0);
        check("t4_full_usedw", 32'(audio_fifo_usedw), 32'd2048);
        check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        send_sector(21'd7, 1, 16'hBEEF, 0);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_overflow_model", 32'(overflow), 32'(m_overflow));
        check("t4_usedw_held", 32'(audio_fifo_usedw), 32'd2048);
        pulse_trig_play();
        check("t4_flush_usedw", 32'(audio_fifo_usedw), 32'd0);
        check("t4_flush_ovf", 32'(overflow), 32'd0);

        // Underruns while playing from an empty FIFO
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        audio_play = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe("t5_strobe", 600, c);
            check("t5_audio_l", 32'(audio_l), 32'd0);
            check("t5_audio_r", 32'(audio_r), 32'd0);
        end
        check("t5_underrun", 32'(underrun_count), 32'd3);
        check("t5_underrun_model", 32'(underrun_count), 32'(m_underrun));
        audio_play = 1'b0;

        // Write landing in the same cycle as the left read
        @(negedge clk);
        sd_lba_1   = 21'd9;
        sd_ack_1   = 1'b1;
        sd_buff_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sd_buff_wr   = 1'b1;
            sd_buff_dout = 16'(16'h6000 + 16'(i));
            model_write(21'd9, i, 1'b0, sd_buff_dout);
        end
        @(negedge clk);
        sd_buff_wr = 1'b0;
        wait_strobe("t6_sync", 600, c);
        audio_play = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!m_tick && c < 600);
        check("t6_tick_seen", 32'(m_tick), 32'd1);
        check("t6_usedw_at_tick", 32'(audio_fifo_usedw), 32'd4);
        @(negedge clk);
        sd_buff_wr   = 1'b1;
        sd_buff_dout = 16'h6ABC;
        model_write(21'd9, 4, 1'b0, sd_buff_dout);
        @(negedge clk);
        sd_buff_wr = 1'b0;
        check("t6_usedw_net", 32'(audio_fifo_usedw), 32'd4);
        wait_strobe("t6_pop", 10, c);
        check("t6_latency", 32'(c), 32'd1);
        check("t6_pair_l", 32'(audio_l), 32'h6000);
        check("t6_pair_r", 32'(audio_r), 32'h6001);
        audio_play = 1'b0;
        sd_ack_1   = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_usedw_end", 32'(audio_fifo_usedw), 32'd3);
        check("t6_no_pending", 32'(pair_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
